// File: rtl/pll_sdm_pkg.sv
// Shared constants and types for the MASH 1-1-1 delta-sigma modulator.
package pll_sdm_pkg;

    // Width and legal range of the noise-shaped divide offset.
    // The 3-bit dn code is two's complement for -3..+3; the otherwise unused
    // code 3'b100 stands for +4 (-4 never occurs in a 1-1-1 MASH).
    localparam int DN_W   = 3;
    localparam int DN_MIN = -3;
    localparam int DN_MAX = 4;

    // Modulator order; there is no order 0, a request for 0 maps to ORD1.
    typedef enum logic [1:0] {
        ORD1 = 2'd1,
        ORD2 = 2'd2,
        ORD3 = 2'd3
    } order_e;

    // Dither LFSR polynomial x^23 + x^18 + 1 (tap positions, 1-based).
    localparam int LFSR_TAP_HI = 23;
    localparam int LFSR_TAP_LO = 18;

    // Map the raw order select onto the enum.
    function automatic order_e decode_order(input logic [1:0] sel);
        case (sel)
            2'd2:    return ORD2;
            2'd3:    return ORD3;
            default: return ORD1;
        endcase
    endfunction

endpackage

// File: rtl/sdm_acc_stage.sv
// One first-order accumulator stage of the MASH chain: W-bit state,
// (W+1)-bit sum, carry is the overflow bit.
module sdm_acc_stage #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic [W-1:0] addend_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o,
    output logic         carry_o
);

    logic [W-1:0] acc_q;
    logic [W:0]   sum_full;

    assign sum_full = {1'b0, acc_q} + {1'b0, addend_i} + {{W{1'b0}}, cin_i};
    assign sum_o    = sum_full[W-1:0];
    assign carry_o  = sum_full[W];

    // Accumulate modulo 2^W on enabled samples; clear wins over accumulate.
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= sum_full[W-1:0];
        end
    end

endmodule

// File: rtl/mash_sdm_ctrl.sv
// MASH 1-1-1 delta-sigma modulator for the fractional-N divider.
// Runtime order 1..3, optional LSB dither on stage 1, double-buffered config,
// registered per-sample divide ratio with saturation flag.
module mash_sdm_ctrl
    import pll_sdm_pkg::*;
#(
    parameter int                ACC_W     = 24,
    parameter int                N_W       = 8,
    parameter int                LFSR_W    = 23,
    parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_W'(1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_load,
    input  logic [ACC_W-1:0] cfg_frac,
    input  logic [N_W-1:0]   cfg_nint,
    input  logic [1:0]       cfg_order,
    input  logic             cfg_dither,
    output logic             cfg_busy,
    output logic [DN_W-1:0]  dn,
    output logic [N_W-1:0]   div_ratio,
    output logic             div_valid,
    output logic             sat_err
);

    // Pending (shadow) and active configuration
    logic [ACC_W-1:0] pend_frac_q, act_frac_q, src_frac, use_frac;
    logic [N_W-1:0]   pend_nint_q, act_nint_q, src_nint, use_nint;
    order_e           pend_order_q, act_order_q, src_order, use_order;
    logic             pend_dither_q, act_dither_q, src_dither, use_dither;
    logic             busy_q;
    logic             apply;

    // Accumulator chain
    logic [2:0]       stage_on;
    logic [ACC_W-1:0] stage_in  [3];
    logic [ACC_W-1:0] stage_sum [3];
    logic [2:0]       stage_carry;
    logic [2:0]       c_now;
    logic             dither_bit;
    logic             unused_last_sum;

    // Carry history and noise cancellation
    logic             c2_d_q, c3_d_q, c3_dd_q;
    logic             c2_d_m, c3_d_m, c3_dd_m;
    logic signed [3:0]     dn_sum;
    logic signed [N_W+1:0] ratio_full;
    int                    dn_lo, dn_hi;

    // Dither LFSR and registered outputs
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [DN_W-1:0]   dn_q;
    logic [N_W-1:0]    ratio_q, ratio_d;
    logic              valid_q, sat_q, sat_d;

    // A load in the same cycle as en bypasses the shadow so it applies at once.
    always_comb begin
        src_frac   = cfg_load ? cfg_frac : pend_frac_q;
        src_nint   = cfg_load ? cfg_nint : pend_nint_q;
        src_order  = cfg_load ? decode_order(cfg_order) : pend_order_q;
        src_dither = cfg_load ? cfg_dither : pend_dither_q;
        apply      = en && (cfg_load || busy_q);
        use_frac   = apply ? src_frac   : act_frac_q;
        use_nint   = apply ? src_nint   : act_nint_q;
        use_order  = apply ? src_order  : act_order_q;
        use_dither = apply ? src_dither : act_dither_q;
    end

    // Stage enables for the order in effect this sample, plus legal dn range.
    always_comb begin
        stage_on = 3'b001;
        dn_lo    = 0;
        dn_hi    = 1;
        case (use_order)
            ORD2: begin
                stage_on = 3'b011;
                dn_lo    = -1;
                dn_hi    = 2;
            end
            ORD3: begin
                stage_on = 3'b111;
                dn_lo    = DN_MIN;
                dn_hi    = DN_MAX;
            end
            default: ;
        endcase
    end

    assign dither_bit = use_dither & lfsr_q[0];

    // Disabled stages are cleared on every enabled sample, which covers the
    // clear-on-order-drop and keeps them at zero until re-enabled.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign stage_in[gi] = use_frac;
            end else begin : g_chain
                assign stage_in[gi] = stage_sum[gi-1];
            end

            sdm_acc_stage #(
                .W(ACC_W)
            ) u_acc (
                .clk      (clk),
                .rst      (rst),
                .en_i     (en),
                .clr_i    (en & ~stage_on[gi]),
                .addend_i (stage_in[gi]),
                .cin_i    ((gi == 0) ? dither_bit : 1'b0),
                .sum_o    (stage_sum[gi]),
                .carry_o  (stage_carry[gi])
            );
        end
    endgenerate

    // The last stage's sum feeds nothing; only its carry is used.
    assign unused_last_sum = ^stage_sum[2];

    // Noise cancellation: dn = c1 + (c2 - c2_d) + (c3 - 2*c3_d + c3_dd),
    // with every term of a disabled stage forced to zero.
    always_comb begin
        c_now   = stage_carry & stage_on;
        c2_d_m  = c2_d_q  & stage_on[1];
        c3_d_m  = c3_d_q  & stage_on[2];
        c3_dd_m = c3_dd_q & stage_on[2];
        dn_sum  = $signed({3'b000, c_now[0]})
                + $signed({3'b000, c_now[1]}) - $signed({3'b000, c2_d_m})
                + $signed({3'b000, c_now[2]}) - $signed({2'b00, c3_d_m, 1'b0})
                + $signed({3'b000, c3_dd_m});
    end

    // Integer plus offset, clamped to the unsigned ratio range.
    always_comb begin
        ratio_full = $signed({2'b00, use_nint}) + $signed({{(N_W-2){dn_sum[3]}}, dn_sum});
        ratio_d    = ratio_full[N_W-1:0];
        sat_d      = sat_q;
        if (ratio_full < 0) begin
            ratio_d = '0;
            sat_d   = 1'b1;
        end else if (ratio_full[N_W]) begin
            ratio_d = '1;
            sat_d   = 1'b1;
        end
    end

    // Fibonacci LFSR step, only when dither is in use this sample.
    always_comb begin
        lfsr_d = lfsr_q;
        if (use_dither) begin
            lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_q[LFSR_TAP_HI-1] ^ lfsr_q[LFSR_TAP_LO-1]};
        end
    end

    // Config double buffer: capture on load, promote on the next enabled sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_frac_q   <= '0;
            pend_nint_q   <= '0;
            pend_order_q  <= ORD1;
            pend_dither_q <= 1'b0;
            act_frac_q    <= '0;
            act_nint_q    <= '0;
            act_order_q   <= ORD1;
            act_dither_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            if (cfg_load) begin
                pend_frac_q   <= cfg_frac;
                pend_nint_q   <= cfg_nint;
                pend_order_q  <= decode_order(cfg_order);
                pend_dither_q <= cfg_dither;
            end
            if (apply) begin
                act_frac_q   <= src_frac;
                act_nint_q   <= src_nint;
                act_order_q  <= src_order;
                act_dither_q <= src_dither;
                busy_q       <= 1'b0;
            end else if (cfg_load) begin
                busy_q <= 1'b1;
            end
        end
    end

    // Sample state and registered outputs advance only on enabled cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q  <= LFSR_SEED;
            c2_d_q  <= 1'b0;
            c3_d_q  <= 1'b0;
            c3_dd_q <= 1'b0;
            dn_q    <= '0;
            ratio_q <= '0;
            valid_q <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            valid_q <= en;
            if (en) begin
                lfsr_q  <= lfsr_d;
                c2_d_q  <= c_now[1];
                c3_d_q  <= c_now[2];
                c3_dd_q <= c3_d_m;
                dn_q    <= dn_sum[DN_W-1:0];
                ratio_q <= ratio_d;
                sat_q   <= sat_d;
            end
        end
    end

    // The cancelled carry sum must stay inside the range of the order in use.
    always_ff @(posedge clk) begin
        if (!rst && en) begin
            assert (int'(dn_sum) >= dn_lo && int'(dn_sum) <= dn_hi);
        end
    end

    assign cfg_busy  = busy_q;
    assign dn        = dn_q;
    assign div_ratio = ratio_q;
    assign div_valid = valid_q;
    assign sat_err   = sat_q;

endmodule

// File: tb/tb_mash_sdm_ctrl.sv
// Scoreboard bench for mash_sdm_ctrl: stimulus pushes expected samples,
// a negedge monitor pops and compares whenever div_valid is high.
module tb_mash_sdm_ctrl;

    localparam int ACC_W = 24;
    localparam int N_W   = 8;
    localparam int LFSR_W = 23;
    localparam logic [22:0] SEED = 23'h1;
    localparam longint ACC_MOD = 64'h1000000;

    logic        clk = 1'b0;
    logic        rst, en, cfg_load, cfg_dither;
    logic [23:0] cfg_frac;
    logic [7:0]  cfg_nint;
    logic [1:0]  cfg_order;
    logic        cfg_busy;
    logic [2:0]  dn;
    logic [7:0]  div_ratio;
    logic        div_valid, sat_err;

    always #5 clk = ~clk;

    mash_sdm_ctrl #(
        .ACC_W(ACC_W), .N_W(N_W), .LFSR_W(LFSR_W), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .cfg_load(cfg_load),
        .cfg_frac(cfg_frac), .cfg_nint(cfg_nint), .cfg_order(cfg_order),
        .cfg_dither(cfg_dither), .cfg_busy(cfg_busy), .dn(dn),
        .div_ratio(div_ratio), .div_valid(div_valid), .sat_err(sat_err)
    );

    typedef struct packed {
        logic [2:0] dn;
        logic [7:0] ratio;
        logic       sat;
    } exp_t;

    exp_t sb_q[$];
    int   got_dn[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic [2:0] hold_dn = '0;
    logic [7:0] hold_ratio = '0;
    logic       hold_sat = 1'b0;

    // Reference model state
    longint      m_acc[3];
    int          m_cd2, m_cd3, m_cdd3;
    logic [22:0] m_lfsr;
    logic [23:0] a_frac, p_frac;
    int          a_nint, p_nint, a_ord, p_ord;
    bit          a_dith, p_dith, m_busy, m_sat;

    function automatic int dn_val(input logic [2:0] v);
        if (v == 3'b100) return 4;
        return int'($signed(v));
    endfunction

    task automatic check(input string nm, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) m_acc[k] = 0;
        m_cd2 = 0; m_cd3 = 0; m_cdd3 = 0;
        m_lfsr = SEED;
        a_frac = '0; p_frac = '0; a_nint = 0; p_nint = 0;
        a_ord = 1; p_ord = 1; a_dith = 0; p_dith = 0;
        m_busy = 0; m_sat = 0;
    endtask

    task automatic model_step(input bit e, input bit ld, input logic [23:0] f,
                              input logic [7:0] n, input logic [1:0] o, input bit di);
        longint s;
        int c1, c2, c3, dv, r;
        exp_t ex;
        if (ld) begin
            p_frac = f; p_nint = int'(n); p_ord = (o == 2'd0) ? 1 : int'(o); p_dith = di;
            m_busy = 1;
        end
        if (e) begin
            if (m_busy) begin
                a_frac = p_frac; a_nint = p_nint; a_ord = p_ord; a_dith = p_dith;
                m_busy = 0;
                if (a_ord < 3) begin m_acc[2] = 0; m_cd3 = 0; m_cdd3 = 0; end
                if (a_ord < 2) begin m_acc[1] = 0; m_cd2 = 0; end
            end
            s = m_acc[0] + longint'(a_frac) + longint'(a_dith & m_lfsr[0]);
            c1 = int'(s / ACC_MOD); m_acc[0] = s % ACC_MOD;
            c2 = 0; c3 = 0;
            if (a_ord >= 2) begin
                s = m_acc[1] + m_acc[0];
                c2 = int'(s / ACC_MOD); m_acc[1] = s % ACC_MOD;
            end
            if (a_ord >= 3) begin
                s = m_acc[2] + m_acc[1];
                c3 = int'(s / ACC_MOD); m_acc[2] = s % ACC_MOD;
            end
            dv = c1 + (c2 - m_cd2) + (c3 - 2 * m_cd3 + m_cdd3);
            m_cdd3 = m_cd3; m_cd3 = c3; m_cd2 = c2;
            if (a_dith) m_lfsr = {m_lfsr[21:0], m_lfsr[22] ^ m_lfsr[17]};
            r = a_nint + dv;
            if (r < 0) begin r = 0; m_sat = 1; end
            else if (r > 255) begin r = 255; m_sat = 1; end
            ex.dn = dv[2:0]; ex.ratio = r[7:0]; ex.sat = m_sat;
            sb_q.push_back(ex);
        end
    endtask

    task automatic step(input bit e, input bit ld, input logic [23:0] f,
                        input logic [7:0] n, input logic [1:0] o, input bit di);
        en = e; cfg_load = ld; cfg_frac = f; cfg_nint = n; cfg_order = o; cfg_dither = di;
        model_step(e, ld, f, n, o, di);
        @(posedge clk); #1;
        en = 1'b0; cfg_load = 1'b0;
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) step(1'b0, 1'b0, 24'h0, 8'h0, 2'd0, 1'b0);
    endtask

    // Reset with en and (optionally) cfg_load high to show rst has priority.
    task automatic do_reset(input bit ld);
        rst = 1'b1; en = 1'b1; cfg_load = ld;
        cfg_frac = 24'hABCDEF; cfg_nint = 8'd99; cfg_order = 2'd3; cfg_dither = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; en = 1'b0; cfg_load = 1'b0;
        model_reset();
        hold_dn = '0; hold_ratio = '0; hold_sat = 1'b0;
        check("rst_dn", int'(dn), 0);
        check("rst_ratio", int'(div_ratio), 0);
        check("rst_valid", int'(div_valid), 0);
        check("rst_busy", int'(cfg_busy), 0);
        check("rst_sat", int'(sat_err), 0);
        check("rst_lfsr", int'(dut.lfsr_q), int'(SEED));
    endtask

    // Monitor: pop on each valid sample, otherwise verify outputs hold.
    always @(negedge clk) begin
        exp_t e;
        if (div_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("dn", dn_val(dn), dn_val(e.dn));
                check("div_ratio", int'(div_ratio), int'(e.ratio));
                check("sat_err", int'(sat_err), int'(e.sat));
                $display("sample dn=%0d ratio=%0d sat=%0d busy=%0d", dn_val(dn), div_ratio, sat_err, cfg_busy);
                got_dn.push_back(dn_val(dn));
                hold_dn = e.dn; hold_ratio = e.ratio; hold_sat = e.sat;
            end
        end else begin
            check("hold_dn", int'(dn), int'(hold_dn));
            check("hold_ratio", int'(div_ratio), int'(hold_ratio));
            check("hold_sat", int'(sat_err), int'(hold_sat));
        end
    end

    initial begin
        int sum;
        int alt[8];
        rst = 1'b1; en = 1'b0; cfg_load = 1'b0; cfg_frac = '0; cfg_nint = '0;
        cfg_order = 2'd0; cfg_dither = 1'b0;
        model_reset();

        // Test 1: frac=0, order 3 -> dn=0, ratio=40 every sample
        do_reset(1'b0);
        got_dn.delete();
        for (int i = 0; i < 16; i++) step(1'b1, i == 0, 24'h0, 8'd40, 2'd3, 1'b0);
        idle(2);
        sum = 0;
        foreach (got_dn[i]) sum += (got_dn[i] != 0) ? 1 : 0;
        check("t1_nonzero_dn", sum, 0);
        check("t1_count", got_dn.size(), 16);
        check("t1_ratio", int'(div_ratio), 40);

        // Test 2: order 1, frac=1/2 -> dn 0,1,0,1...
        do_reset(1'b0);
        got_dn.delete();
        for (int i = 0; i < 8; i++) step(1'b1, i == 0, 24'h800000, 8'd10, 2'd1, 1'b0);
        idle(1);
        alt = '{0, 1, 0, 1, 0, 1, 0, 1};
        for (int i = 0; i < 8; i++) check($sformatf("t2_dn%0d", i), got_dn[i], alt[i]);

        // Test 3: order 3, frac=1/4, 1024 samples -> sum(dn) near 256
        do_reset(1'b0);
        got_dn.delete();
        for (int i = 0; i < 1024; i++) step(1'b1, i == 0, 24'h400000, 8'd64, 2'd3, 1'b0);
        idle(1);
        sum = 0;
        foreach (got_dn[i]) sum += got_dn[i];
        check("t3_sum_in_range", int'(sum >= 253 && sum <= 259), 1);
        // Same config with dither enabled
        for (int i = 0; i < 64; i++) step(1'b1, i == 0, 24'h400000, 8'd64, 2'd3, 1'b1);
        idle(1);

        // Test 4: double-buffered config
        step(1'b0, 1'b1, 24'h800000, 8'd20, 2'd1, 1'b0);
        check("t4_busy0", int'(cfg_busy), 1);
        for (int i = 1; i < 5; i++) begin
            step(1'b0, 1'b0, 24'h0, 8'd0, 2'd0, 1'b0);
            check($sformatf("t4_busy%0d", i), int'(cfg_busy), 1);
        end
        step(1'b0, 1'b1, 24'h400000, 8'd30, 2'd2, 1'b0);
        check("t4_busy_last_wins", int'(cfg_busy), 1);
        step(1'b1, 1'b0, 24'h0, 8'd0, 2'd0, 1'b0);
        check("t4_busy_cleared", int'(cfg_busy), 0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 24'h0, 8'd0, 2'd0, 1'b0);
        step(1'b1, 1'b1, 24'h800000, 8'd12, 2'd0, 1'b0);
        check("t4_same_edge_busy", int'(cfg_busy), 0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 24'h0, 8'd0, 2'd0, 1'b0);
        idle(1);

        // Test 5: saturation low (nint=0) then high (nint=255)
        do_reset(1'b0);
        for (int i = 0; i < 64; i++) step(1'b1, i == 0, 24'h800001, 8'd0, 2'd3, 1'b0);
        idle(1);
        check("t5_sat_low", int'(sat_err), 1);
        for (int i = 0; i < 8; i++) step(1'b1, i == 0, 24'h800000, 8'd255, 2'd1, 1'b0);
        idle(1);
        check("t5_sat_sticky", int'(sat_err), 1);
        check("t5_ratio_high", int'(div_ratio), 255);

        // Test 6: reset mid-stream with cfg_load high; config must not be captured
        do_reset(1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, i == 0, 24'h555555, 8'd100, 2'd3, 1'b1);
        do_reset(1'b1);
        got_dn.delete();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 24'h0, 8'd0, 2'd0, 1'b0);
        idle(2);
        check("t6_ratio_after_rst", int'(div_ratio), 0);
        check("t6_dn_after_rst", got_dn.size() > 0 ? got_dn[got_dn.size()-1] : -99, 0);

        check("sb_drained", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mash_sdm_ctrl.md
Name: mash_sdm_ctrl

Overview:
- Synthesisable, parametrised MASH 1-1-1 delta-sigma modulator for the fractional-N divider control path.
- Runtime-selectable order 1..3 and an optional LFSR LSB dither on stage 1.
- Double-buffered update of the fraction and integer ratio.
- Clocked by the divided feedback clock. Combines the integer part with the noise-cancelled carry sum and outputs the per-cycle divide ratio directly.

Parameters:
ACC_W, 24, accumulator and fraction width (bits)
N_W, 8, integer/divide-ratio width (unsigned)
LFSR_W, 23, dither LFSR length (taps fixed for 23: x^23+x^18+1)
LFSR_SEED, 23'h1, LFSR reset value (must be non-zero)

Ports:
clk  in  1  divider feedback clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
en  in  1  advance modulator one sample this cycle
cfg_load  in  1  single-cycle pulse: capture cfg_* into the pending shadow
cfg_frac  in  ACC_W  fractional word, value = cfg_frac / 2^ACC_W
cfg_nint  in  N_W  integer part N
cfg_order  in  2  order select: 1, 2 or 3; 0 is treated as 1
cfg_dither  in  1  enable LSB dither into stage 1
cfg_busy  out  1  pending config not yet applied
dn  out  3  signed noise-shaped offset, range -3..+4
div_ratio  out  N_W  n_int + dn, saturated to [0, 2^N_W-1]
div_valid  out  1  div_ratio/dn updated this cycle
sat_err  out  1  sticky: a div_ratio saturation occurred; cleared only by rst

Behaviour:
- Reset (rst=1 at edge):
  - All accumulators, carry delay registers, dn, div_ratio, div_valid, cfg_busy and sat_err go to 0.
  - Active and pending config go to 0; cfg_order reads as 1.
  - LFSR goes to LFSR_SEED.
  - rst has priority over en and cfg_load in the same cycle.
- Config double buffer:
  - cfg_load captures into pending and sets cfg_busy=1.
  - The pending config is copied to active on the first en=1 edge after capture, including the same edge if cfg_load and en are both high. That copy clears cfg_busy.
  - The sample processed on that edge already uses the new active config.
  - A second cfg_load while busy overwrites pending (last wins).
- Order change on apply: accumulators and carry delays of stages above the new order are cleared; lower stages keep their state.
- Per en=1 edge, with f = active frac, and W = ACC_W (all sums are (W+1)-bit, carry = bit W, state keeps bits [W-1:0]):
  - d = LFSR[0] if dither on, else 0.
  - s1 = acc1 + f + d; c1 = s1[W].
  - s2 = acc2 + s1[W-1:0]; c2 = s2[W].
  - s3 = acc3 + s2[W-1:0]; c3 = s3[W].
  - Carries of disabled stages are forced to 0.
  - Noise cancellation: dn = c1 + (c2 - c2_d) + (c3 - 2*c3_d + c3_dd), where _d/_dd are the previous en-sample carries.
  - div_ratio = nint + dn; if the result is <0 or >2^N_W-1, clamp and set sat_err.
  - Outputs are registered: latency is 1 clk from the en edge. div_valid=1 for exactly that cycle.
  - The LFSR advances only on en edges with dither on.
- en=0: all state holds and div_valid=0. Outputs dn and div_ratio hold their last values.
- Wrap-around: accumulators are modulo 2^ACC_W. f=0 with dither off yields c*=0 forever.
- Boundary on dn range: order 1 gives 0..1; order 2 gives -1..2; order 3 gives -3..4. Any value outside the range is a design error (assertion).

Decomposition:
- Shared package pll_sdm_pkg holds:
  - DN_W=3, DN_MIN=-3, DN_MAX=4
  - the order enum (ORD1, ORD2, ORD3)
  - LFSR tap constants
- Sub-module sdm_acc_stage (one per order, instantiated 3x): W-bit accumulator with en, sync clear and carry out. It exposes sum bits and carry.
- Noise-cancel network, config buffer and LFSR stay in the top level.

Test Plan:
- Reset then order=3, frac=0, nint=40, dither off, en=1 constant -> dn=0 and div_ratio=40 every cycle; div_valid high one cycle after each en.
- Order=1, frac=2^23, nint=10 -> dn sequence 0,1,0,1,...; div_ratio 10,11,10,11,...
- Order=3, frac=2^22, nint=64, 1024 en cycles -> sum(dn) within 256±3; dn always in -3..4; the dn sequence matches a golden model bit-exactly.
- cfg_load with en=0 for 5 cycles -> cfg_busy=1 and outputs hold; first en edge applies the new frac, busy drops, and the next dn reflects the new config. cfg_load and en in the same cycle -> the config applies on that edge.
- nint=0, order=3, frac=2^23+1 -> a negative dn clamps div_ratio to 0 and sat_err sets and stays set. nint=255 with positive dn clamps to 255.
- Mid-run rst pulse during an active order-3 stream, with cfg_load high in the same cycle -> all outputs and state are 0 next cycle, config is not captured, and the LFSR equals LFSR_SEED.
